regfile_writeback_queue: RTL and testbench
==========================================

# regfile_writeback_queue

Write-side front end for the CPU's 32-entry register file. It accepts register writeback requests from two producers: the main pipeline (port A) and the long-latency multiply/divide/load unit (port B). Requests are buffered in a small in-order FIFO and drained to the register file's write port at one write per cycle. Two lookup ports report the youngest still-pending value for any register, so the decode stage can forward values that have not yet been written to the register file.

## Interface
Parameters:
- DATA_BITS, 32, register data width
- ADDR_BITS, 5, register address width
- QUEUE_DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- a_valid  in  1  pipeline write request
- a_ready  out  1  pipeline request accepted this cycle
- a_addr  in  ADDR_BITS  destination register
- a_data  in  DATA_BITS  write value
- b_valid  in  1  long-latency unit write request
- b_ready  out  1  long-latency request accepted this cycle
- b_addr  in  ADDR_BITS  destination register
- b_data  in  DATA_BITS  write value
- WriteEnable  out  1  register file write strobe
- DAddress  out  ADDR_BITS  register file write address
- DData  out  DATA_BITS  register file write data
- AAddress  in  ADDR_BITS  lookup port A address
- AHit  out  1  lookup A has a pending write
- AFwd  out  DATA_BITS  youngest pending value for AAddress
- BAddress  in  ADDR_BITS  lookup port B address
- BHit  out  1  lookup B has a pending write
- BFwd  out  DATA_BITS  youngest pending value for BAddress
- count  out  clog2(QUEUE_DEPTH)+1  number of occupied entries
- idle  out  1  high when count == 0

## Operation
- **State:** circular FIFO with entries {addr, data}, head pointer, tail pointer and count register.
- **Drain:**
  - WriteEnable = (count != 0). DAddress and DData show the head entry.
  - When the queue is empty, DAddress and DData are 0.
  - The head entry is popped on every edge where WriteEnable is 1. The register file has no backpressure.
- **Free slots this cycle:** free = QUEUE_DEPTH − count + (count != 0 ? 1 : 0).
- **Address-0 requests:** valid requests with address 0 are accepted (ready high, regardless of free) and discarded. They never occupy an entry.
- **Acceptance:**
  - a_ready = (a_addr == 0) or (free ≥ 1).
  - b_ready = (b_addr == 0) or (free ≥ 1 + need_a), where need_a = a_valid & (a_addr != 0) & (free ≥ 1).
- **Same-cycle enqueue order:** when both sources are accepted in one cycle, A is enqueued before B. B is therefore younger.
- **Handshake rules:**
  - A transfer occurs when valid & ready are both high at the edge.
  - The producer must hold valid, addr and data stable until the transfer.
  - valid must not depend on ready.
- **Lookup:**
  - xHit = 1 when any occupied entry, including the head being drained this cycle, has addr == xAddress and xAddress != 0.
  - xFwd = data of the youngest matching entry. xFwd = 0 when there is no hit.
  - Lookup is combinational on registered state. Same-cycle incoming requests are not visible.
- **Duplicate addresses:** multiple entries to the same register are all written, in order. No merging.
- **count update:** count_next = count + enqueued − popped. Pointers wrap modulo QUEUE_DEPTH.

## Timing
- **Reset** (asynchronous, during or between operations): pending entries are discarded. count = 0, pointers = 0.
  - WriteEnable = 0, DAddress = 0, DData = 0, AHit = BHit = 0, AFwd = BFwd = 0, idle = 1.
  - a_ready = b_ready = 1 (empty queue).
- **Latency:** a request accepted at edge N drives WriteEnable at cycle N+1 if it is at the head. It is written to the register file at edge N+1.
- **Throughput:** sustained one write per cycle. Two requests per cycle fill the queue at a net +1 per cycle.
- **Full queue:** free = 1 because the head pops this cycle. One non-zero request is still accepted.
- **Empty queue:** free = QUEUE_DEPTH.
- **Simultaneous pop and push:** count is unchanged. The popped head is still visible to lookups during that cycle.

## Test plan
1. **Reset then single write:** reset, then a_valid with a_addr=3, a_data=0xDEADBEEF for one cycle. Required: next cycle WriteEnable=1, DAddress=3, DData=0xDEADBEEF, AHit=1 for AAddress=3. The cycle after: idle=1.
2. **Dual request ordering:** A (5, 0x11) and B (5, 0x22) in the same cycle. Required: writes appear on consecutive cycles in order 0x11 then 0x22. In the first drain cycle AFwd(5)=0x22, in the second AFwd(5)=0x22, then AHit=0.
3. **Fill and backpressure:**
   - Drive both ports with non-zero addresses every cycle, QUEUE_DEPTH=4. Required: count reaches 4, then b_ready=0 while a_ready=1. After that, one write per cycle with no loss or reorder against a scoreboard.
   - Both ports use address 0 when count=4. Required: both ready, count unchanged.
4. **Address-0 requests:** a_addr=0, a_data=0xFFFFFFFF. Required: a_ready=1, WriteEnable stays 0, AHit=0 for AAddress=0.
5. **Reset mid-operation:** queue holding 3 entries, assert rst_n=0 asynchronously between edges. Required: immediately WriteEnable=0, count=0, AHit=BHit=0. After release, no stale writes appear.
6. **Random stress:** 10k cycles of random valid/addr/data on both ports. Required: the register file model matches a reference sequence in acceptance order. The lookup outputs always equal the youngest pending value.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// Write-side front end for the register file. Two producers feed an in-order
// FIFO that drains one write per cycle. Two lookup ports return the youngest
// pending value for a register so decode can forward it.
module regfile_writeback_queue #(
  parameter int unsigned DATA_BITS   = 32,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [ADDR_BITS-1:0]           a_addr,
  input  logic [DATA_BITS-1:0]           a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [ADDR_BITS-1:0]           b_addr,
  input  logic [DATA_BITS-1:0]           b_data,
  output logic                           WriteEnable,
  output logic [ADDR_BITS-1:0]           DAddress,
  output logic [DATA_BITS-1:0]           DData,
  input  logic [ADDR_BITS-1:0]           AAddress,
  output logic                           AHit,
  output logic [DATA_BITS-1:0]           AFwd,
  input  logic [ADDR_BITS-1:0]           BAddress,
  output logic                           BHit,
  output logic [DATA_BITS-1:0]           BFwd,
  output logic [$clog2(QUEUE_DEPTH):0]   count,
  output logic                           idle
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [ADDR_BITS-1:0] addr_q [QUEUE_DEPTH];
  logic [DATA_BITS-1:0] data_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [PTR_W-1:0]     tail_b_c;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 pop_c;
  logic [CNT_W-1:0]     free_c;
  logic                 a_nz_c, b_nz_c;
  logic                 need_a_c;
  logic                 push_a_c, push_b_c;

  logic [PTR_W-1:0]       slot_c [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] occ_c;

  // Flow control: the head always pops when present, so it frees a slot this cycle.
  always_comb begin
    pop_c    = (count_q != '0);
    free_c   = CNT_W'(QUEUE_DEPTH) - count_q + CNT_W'(pop_c);
    a_nz_c   = (a_addr != '0);
    b_nz_c   = (b_addr != '0);
    need_a_c = a_valid & a_nz_c & (free_c >= CNT_W'(1));
    a_ready  = ~a_nz_c | (free_c >= CNT_W'(1));
    b_ready  = ~b_nz_c | (free_c >= (CNT_W'(1) + CNT_W'(need_a_c)));
    push_a_c = a_valid & a_ready & a_nz_c;
    push_b_c = b_valid & b_ready & b_nz_c;
    tail_b_c = tail_q + PTR_W'(push_a_c);
    head_d   = head_q + PTR_W'(pop_c);
    tail_d   = tail_q + PTR_W'(push_a_c) + PTR_W'(push_b_c);
    count_d  = count_q + CNT_W'(push_a_c) + CNT_W'(push_b_c) - CNT_W'(pop_c);
  end

  // Pointer, occupancy and entry storage; A lands before B when both push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_a_c) begin
        addr_q[tail_q] <= a_addr;
        data_q[tail_q] <= a_data;
      end
      if (push_b_c) begin
        addr_q[tail_b_c] <= b_addr;
        data_q[tail_b_c] <= b_data;
      end
    end
  end

  // Drain port: head entry, zeroed when the queue is empty.
  always_comb begin
    WriteEnable = pop_c;
    DAddress    = pop_c ? addr_q[head_q] : '0;
    DData       = pop_c ? data_q[head_q] : '0;
    count       = count_q;
    idle        = (count_q == '0);
  end

  // Physical slot and occupancy for each age position, oldest first.
  always_comb begin
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      slot_c[i] = head_q + PTR_W'(i);
      occ_c[i]  = (CNT_W'(i) < count_q);
    end
  end

  // Forwarding lookup: scanning oldest to youngest lets the youngest match win.
  always_comb begin
    AHit = 1'b0;
    AFwd = '0;
    BHit = 1'b0;
    BFwd = '0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      if (occ_c[i] && (AAddress != '0) && (addr_q[slot_c[i]] == AAddress)) begin
        AHit = 1'b1;
        AFwd = data_q[slot_c[i]];
      end
      if (occ_c[i] && (BAddress != '0) && (addr_q[slot_c[i]] == BAddress)) begin
        BHit = 1'b1;
        BFwd = data_q[slot_c[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: the driver pushes accepted
// requests into an expected queue; a negedge monitor pops it on each write
// and checks lookups against the pending contents.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        WriteEnable;
  logic [4:0]  DAddress;
  logic [31:0] DData;
  logic [4:0]  AAddress, BAddress;
  logic        AHit, BHit;
  logic [31:0] AFwd, BFwd;
  logic [2:0]  count;
  logic        idle;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DATA_BITS(32), .ADDR_BITS(5), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .WriteEnable(WriteEnable), .DAddress(DAddress), .DData(DData),
    .AAddress(AAddress), .AHit(AHit), .AFwd(AFwd),
    .BAddress(BAddress), .BHit(BHit), .BFwd(BFwd),
    .count(count), .idle(idle)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  ent_t pa, pb;
  bit   pa_v = 1'b0, pb_v = 1'b0;
  bit   chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mlook(input logic [4:0] ad, output logic hit, output logic [31:0] fwd);
    hit = 1'b0;
    fwd = '0;
    if (ad != 5'd0)
      foreach (q[i]) if (q[i].a == ad) begin hit = 1'b1; fwd = q[i].d; end
  endfunction

  // Monitor: lookups against pending model, then drain against scoreboard head.
  logic        mh;
  logic [31:0] mf;
  ent_t        me;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      mlook(AAddress, mh, mf);
      check("AHit", AHit, mh);
      check("AFwd", AFwd, mf);
      mlook(BAddress, mh, mf);
      check("BHit", BHit, mh);
      check("BFwd", BFwd, mf);
      if (q.size() != 0) begin
        me = q.pop_front();
        check("WriteEnable", WriteEnable, 1);
        check("DAddress", DAddress, me.a);
        check("DData", DData, me.d);
      end else begin
        check("WriteEnable_empty", WriteEnable, 0);
        check("DAddress_empty", DAddress, 0);
        check("DData_empty", DData, 0);
      end
    end
  end

  // One cycle of stimulus: commit last cycle's acceptances, drive, check readies.
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                      output bit acc_a, output bit acc_b);
    int sz, fr;
    bit na, ear, ebr;
    @(posedge clk);
    if (pa_v) q.push_back(pa);
    if (pb_v) q.push_back(pb);
    pa_v = 1'b0;
    pb_v = 1'b0;
    #1;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    sz  = q.size();
    fr  = DEPTH - sz + ((sz != 0) ? 1 : 0);
    na  = av && (aa != 5'd0) && (fr >= 1);
    ear = (aa == 5'd0) || (fr >= 1);
    ebr = (ba == 5'd0) || (fr >= 1 + int'(na));
    if (chk_en) begin
      check("count", 32'(count), 32'(sz));
      check("idle", idle, (sz == 0));
      check("a_ready", a_ready, ear);
      check("b_ready", b_ready, ebr);
    end
    acc_a = av && ear;
    acc_b = bv && ebr;
    if (acc_a && aa != 5'd0) begin pa_v = 1'b1; pa = '{a: aa, d: ad}; end
    if (acc_b && ba != 5'd0) begin pb_v = 1'b1; pb = '{a: ba, d: bd}; end
  endtask

  task automatic idle_step();
    bit ka, kb;
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ka, kb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ka, kb, ha, hb;
    logic [4:0]  xa, xb;
    logic [31:0] da, db;
    int maxc;

    rst_n = 1'b0;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    AAddress = 5'd3; BAddress = 5'd0;
    #8;
    check("rst_WriteEnable", WriteEnable, 0);
    check("rst_count", 32'(count), 0);
    check("rst_idle", idle, 1);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    check("rst_AHit", AHit, 0);
    #4 rst_n = 1'b1;
    chk_en = 1'b1;

    // Single write
    step(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'd0, ka, kb);
    idle_step();
    check("t1_WE", WriteEnable, 1);
    check("t1_DAddress", DAddress, 3);
    check("t1_DData", DData, 32'hDEADBEEF);
    check("t1_AHit", AHit, 1);
    idle_step();
    check("t1_idle", idle, 1);

    // Dual request to the same register
    AAddress = 5'd5; BAddress = 5'd5;
    step(1, 5'd5, 32'h11, 1, 5'd5, 32'h22, ka, kb);
    idle_step();
    check("t2_DData0", DData, 32'h11);
    check("t2_AFwd0", AFwd, 32'h22);
    idle_step();
    check("t2_DData1", DData, 32'h22);
    check("t2_AFwd1", AFwd, 32'h22);
    idle_step();
    check("t2_AHit_clear", AHit, 0);

    // Fill with both ports every cycle
    ha = 0; hb = 0; maxc = 0; xa = 0; xb = 0; da = 0; db = 0;
    AAddress = 5'd2; BAddress = 5'd4;
    for (int i = 0; i < 10; i++) begin
      if (!ha) begin ha = 1; xa = 5'(i % 7 + 1); da = 32'h1000 + 32'(i); end
      if (!hb) begin hb = 1; xb = 5'(i % 5 + 1); db = 32'h2000 + 32'(i); end
      step(ha, xa, da, hb, xb, db, ka, kb);
      if (ka) ha = 0;
      if (kb) hb = 0;
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("t3_count_max", 32'(maxc), 4);
    check("t3_full_b_ready", b_ready, 0);
    check("t3_full_a_ready", a_ready, 1);
    step(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hEEEEEEEE, ka, kb);
    check("t3_zero_count", 32'(count), 4);
    check("t3_zero_a_ready", a_ready, 1);
    check("t3_zero_b_ready", b_ready, 1);
    idle_step();
    check("t3_after_zero_count", 32'(count), 3);
    repeat (5) idle_step();

    // Address-0 request on an empty queue
    AAddress = 5'd0;
    step(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, ka, kb);
    check("t4_a_ready", a_ready, 1);
    idle_step();
    check("t4_WE", WriteEnable, 0);
    check("t4_AHit", AHit, 0);

    // Asynchronous reset with three entries pending
    AAddress = 5'd4; BAddress = 5'd6;
    step(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, ka, kb);
    step(1, 5'd4, 32'hA4, 1, 5'd6, 32'hB6, ka, kb);
    idle_step();
    check("t5_count_pre", 32'(count), 3);
    #1 rst_n = 1'b0;
    #1;
    check("t5_WE", WriteEnable, 0);
    check("t5_count", 32'(count), 0);
    check("t5_AHit", AHit, 0);
    check("t5_BHit", BHit, 0);
    q.delete();
    pa_v = 1'b0;
    pb_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle_step();

    // Random stress with held requests until accepted
    ha = 0; hb = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!ha) begin ha = ($urandom_range(0, 3) != 0); xa = 5'($urandom_range(0, 7)); da = $urandom; end
      if (!hb) begin hb = ($urandom_range(0, 3) != 0); xb = 5'($urandom_range(0, 7)); db = $urandom; end
      AAddress = 5'($urandom_range(0, 7));
      BAddress = 5'($urandom_range(0, 7));
      step(ha, xa, da, hb, xb, db, ka, kb);
      if (ka) ha = 0;
      if (kb) hb = 0;
    end
    repeat (8) idle_step();
    check("final_idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
